ps2_host_tx: RTL and testbench

//  PS/2 host-to-device transmitter; the send direction of the ps2host receiver. Runs on dot_clk.

---
 rtl/ps2_pkg.sv | 33 +++
 rtl/ps2_line_filter.sv | 39 +++
 rtl/ps2_host_tx.sv | 162 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame constants and
// default inhibit/timeout values used by both the host transmitter and receiver.
package ps2_pkg;

  // Host-to-device transmit sequence.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INHIBIT  = 3'd1,
    ST_START    = 3'd2,
    ST_DATA     = 3'd3,
    ST_PARITY   = 3'd4,
    ST_STOP     = 3'd5,
    ST_ACK_WAIT = 3'd6
  } tx_state_t;

  // Data bits per PS/2 frame and the width of a counter that can hold that value.
  localparam int BITS_PER_BYTE = 8;
  localparam int BIT_CNT_W     = 4;

  // Consecutive identical samples required before the filtered line level changes.
  localparam int FILTER_LEN = 4;

  // Defaults sized for a 7.88 MHz dot clock.
  localparam int DEF_INHIBIT_CYCLES = 1024;    // >= 100 us clock inhibit
  localparam int DEF_TIMEOUT_CYCLES = 131072;  // ~16.6 ms device silence limit
  localparam int DEF_TO_W           = 17;

  // PS/2 uses odd parity: the parity bit makes the count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one raw open-drain PS/2 line: two-flop synchroniser, a
// FILTER_LEN-sample glitch filter, and a one-cycle strobe on a filtered 1->0 edge.
module ps2_line_filter
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic line_i,
  output logic level,
  output logic fall
);

  logic [1:0]            sync_q;
  logic [FILTER_LEN-1:0] hist_q;

  // Synchronise, keep a short sample history and only follow the line once it is stable.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: the filter resets to the idle-high level so leaving reset never fakes an edge.
      sync_q <= '1;
      hist_q <= '1;
      level  <= 1'b1;
      fall   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let each stage read the previous stage's old value,
      // which is exactly what a shift chain needs; blocking ones would collapse the chain.
      sync_q <= {sync_q[0], line_i};
      hist_q <= {hist_q[FILTER_LEN-2:0], sync_q[1]};
      fall   <= 1'b0;
      if (&hist_q) begin
        level <= 1'b1;
      end else if (~|hist_q) begin
        level <= 1'b0;
        fall  <= level;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Inhibits the bus, issues a start bit, then
// shifts data, odd parity and stop out on device clock falls, checks the
// device ACK and waits for both lines to return high. Lines are open-drain:
// an *_oe of 1 pulls the line low.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TO_W           = DEF_TO_W
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2c_i,
  input  logic       ps2d_i,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_busy,
  output logic       tx_done_tick,
  output logic       tx_err_tick
);

  localparam logic [TO_W-1:0]      INHIBIT_LAST = TO_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]      TIMEOUT_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT     = BIT_CNT_W'(BITS_PER_BYTE);

  tx_state_t            state;
  logic [7:0]           shreg;
  logic                 par_q;
  logic [BIT_CNT_W-1:0] bitcnt;
  logic [TO_W-1:0]      cnt;

  logic clk_level;
  logic clk_fall;
  logic data_level;
  logic unused_data_fall;  // the transmitter never needs data-line edges

  ps2_line_filter u_clk_filt (
    .clk    (clk),
    .rstn   (rstn),
    .line_i (ps2c_i),
    .level  (clk_level),
    .fall   (clk_fall)
  );

  ps2_line_filter u_data_filt (
    .clk    (clk),
    .rstn   (rstn),
    .line_i (ps2d_i),
    .level  (data_level),
    .fall   (unused_data_fall)
  );

  // Frame sequencer: one register set for state, shift data, counters and all outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      shreg        <= '0;
      par_q        <= 1'b0;
      bitcnt       <= '0;
      cnt          <= '0;
      ps2c_oe      <= 1'b0;
      ps2d_oe      <= 1'b0;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
      tx_err_tick  <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      tx_err_tick  <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          ps2c_oe <= 1'b0;
          ps2d_oe <= 1'b0;
          cnt     <= '0;
          if (tx_start) begin
            shreg   <= tx_data;
            par_q   <= odd_parity(tx_data);
            bitcnt  <= '0;
            tx_busy <= 1'b1;
            ps2c_oe <= 1'b1;   // inhibit starts on the accept edge
            state   <= ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          // Clock held low; the start bit goes out while the clock is still held,
          // and the clock is released one cycle later on entry to START.
          if (cnt == INHIBIT_LAST) begin
            cnt     <= '0;
            ps2d_oe <= 1'b1;
            state   <= ST_START;
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end

        // START..ACK_WAIT share the device-silence timeout; an unused encoding
        // also lands here and drains to IDLE through the timeout.
        default: begin
          ps2c_oe <= 1'b0;
          if (cnt == TIMEOUT_LAST) begin
            ps2d_oe     <= 1'b0;
            tx_err_tick <= 1'b1;
            tx_busy     <= 1'b0;
            cnt         <= '0;
            state       <= ST_IDLE;
          end else if (state == ST_ACK_WAIT) begin
            cnt <= clk_fall ? '0 : cnt + TO_W'(1);
            if (clk_level && data_level) begin
              tx_done_tick <= 1'b1;
              tx_busy      <= 1'b0;
              cnt          <= '0;
              state        <= ST_IDLE;
            end
          end else if (clk_fall) begin
            // Every device clock fall restarts the silence timer and advances the frame.
            cnt <= '0;
            case (state)
              ST_START: begin
                ps2d_oe <= ~shreg[0];
                shreg   <= shreg >> 1;
                bitcnt  <= BIT_CNT_W'(1);
                state   <= ST_DATA;
              end
              ST_DATA: begin
                if (bitcnt == LAST_BIT) begin
                  ps2d_oe <= ~par_q;
                  state   <= ST_PARITY;
                end else begin
                  ps2d_oe <= ~shreg[0];
                  shreg   <= shreg >> 1;
                  bitcnt  <= bitcnt + BIT_CNT_W'(1);
                end
              end
              ST_PARITY: begin
                ps2d_oe <= 1'b0;   // stop bit is the released line
                state   <= ST_STOP;
              end
              ST_STOP: begin
                // The device must be holding data low as its ACK on this fall.
                if (data_level) begin
                  tx_err_tick <= 1'b1;
                  tx_busy     <= 1'b0;
                  state       <= ST_IDLE;
                end else begin
                  state <= ST_ACK_WAIT;
                end
              end
              default: ;
            endcase
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a behavioural keyboard drives the bus,
// reads each frame back bit by bit and compares it with a frame built from the
// byte by plain arithmetic; a per-cycle monitor checks bus and handshake rules.
module tb_ps2_host_tx;

  localparam int INH = 1024;
  localparam int TMO = 4096;
  localparam int TOW = 13;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       dev_c = 1'b0;   // 1 = keyboard pulls clock low
  logic       dev_d = 1'b0;   // 1 = keyboard pulls data low
  logic       ps2c_line, ps2d_line;
  logic       ps2c_oe, ps2d_oe, tx_busy, tx_done_tick, tx_err_tick;

  assign ps2c_line = ~(ps2c_oe | dev_c);
  assign ps2d_line = ~(ps2d_oe | dev_d);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .TO_W           (TOW)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .ps2c_i       (ps2c_line),
    .ps2d_i       (ps2d_line),
    .ps2c_oe      (ps2c_oe),
    .ps2d_oe      (ps2d_oe),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick),
    .tx_err_tick  (tx_err_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference frame as seen on the wire: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_model(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2 == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  // ---------------- per-cycle monitor ----------------
  int   done_cnt = 0, err_cnt = 0, starts = 0, fall_cnt = 0;
  int   inhib_cycles = 0, dlow_cycles = 0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    if (!tx_busy)
      check("idle_lines_released", 32'({ps2c_oe, ps2d_oe}), 32'd0);
    if (tx_done_tick || tx_err_tick)
      check("pulse_on_busy_fall", 32'({prev_busy, tx_busy, tx_done_tick & tx_err_tick}), 32'b100);
    if (prev_busy && !tx_busy && rstn)
      check("busy_fall_has_pulse", 32'(tx_done_tick | tx_err_tick), 32'd1);
    if (tx_done_tick) done_cnt++;
    if (tx_err_tick)  err_cnt++;
    if (dut.u_clk_filt.fall) fall_cnt++;
    if (!prev_busy && tx_busy) begin
      starts++;
      inhib_cycles = 0;
      dlow_cycles  = 0;
    end
    if (tx_busy && ps2c_oe && !ps2d_oe) inhib_cycles++;
    if (ps2d_oe) dlow_cycles++;
    prev_busy = tx_busy;
  end

  // ---------------- keyboard model ----------------
  task automatic wait_line(input bit on_clk, input logic lvl, input int budget,
                           input string name, output bit ok);
    int n = 0;
    while (((on_clk ? ps2c_line : ps2d_line) !== lvl) && n <= budget) begin
      @(negedge clk);
      n++;
    end
    ok = (n <= budget);
    check(name, 32'(ok), 32'd1);
  endtask

  // mode 0: normal with ACK, 1: no ACK, 2: never clocks, 3: reset during data bit 4
  task automatic device_frame(input int mode, input int h, input bit glitch,
                              output logic [10:0] bits);
    bit ok;
    bits = '0;
    wait_line(1'b1, 1'b0, 3 * INH, "dev_sees_inhibit", ok);
    if (!ok) return;
    wait_line(1'b1, 1'b1, 2 * INH, "dev_sees_clk_release", ok);
    if (!ok) return;
    bits[0] = ps2d_line;
    if (mode == 2) return;
    repeat (h) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && mode == 0) begin
        dev_d = 1'b1;
        repeat (h / 2) @(negedge clk);
      end
      dev_c = 1'b1;
      if (mode == 3 && k == 5) begin
        repeat (h / 2) @(negedge clk);
        check("rst_frame_in_progress", 32'(tx_busy), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        check("rst_clk_oe",  32'(ps2c_oe), 32'd0);
        check("rst_data_oe", 32'(ps2d_oe), 32'd0);
        check("rst_busy",    32'(tx_busy), 32'd0);
        check("rst_pulses",  32'({tx_done_tick, tx_err_tick}), 32'd0);
        @(negedge clk);
        rstn  = 1'b1;
        dev_c = 1'b0;
        return;
      end
      if (glitch && k == 3) begin
        // Short release inside the low phase; the filter must not see a second fall.
        repeat (h / 2) @(negedge clk);
        dev_c = 1'b0;
        repeat (2) @(negedge clk);
        dev_c = 1'b1;
        repeat (h - h / 2 - 2) @(negedge clk);
      end else begin
        repeat (h) @(negedge clk);
      end
      if (k <= 10) bits[k] = ps2d_line;
      dev_c = 1'b0;
      repeat (h) @(negedge clk);
      if (k == 11) dev_d = 1'b0;
    end
  endtask

  // Issue one byte, play the keyboard, wait for the host to go idle, report pulse counts.
  task automatic run_frame(input logic [7:0] d, input int mode, input int h, input bit glitch,
                           output logic [10:0] bits, output int dd, output int de);
    int  d0, e0, n;
    d0 = done_cnt;
    e0 = err_cnt;
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    device_frame(mode, h, glitch, bits);
    n = 0;
    while (tx_busy && n <= 2 * (TMO + INH)) begin
      @(negedge clk);
      n++;
    end
    check("frame_ends", 32'(n <= 2 * (TMO + INH)), 32'd1);
    @(negedge clk);
    dd = done_cnt - d0;
    de = err_cnt - e0;
  endtask

  task automatic idle_glitch(input int len, input int exp_falls, input string name);
    int f0, s0;
    f0 = fall_cnt;
    s0 = starts;
    dev_c = 1'b1;
    repeat (len) @(negedge clk);
    dev_c = 1'b0;
    repeat (20) @(negedge clk);
    check(name, 32'(fall_cnt - f0), 32'(exp_falls));
    check({name, "_no_start"}, 32'(starts - s0), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #(10 * 150000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [10:0] bits;
    int          dd, de, s0, n;
    logic [7:0]  rd;
    int          rh;
    bit          rg;

    rstn = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_clk_oe",  32'(ps2c_oe), 32'd0);
    check("reset_data_oe", 32'(ps2d_oe), 32'd0);
    check("reset_busy",    32'(tx_busy), 32'd0);
    check("reset_pulses",  32'({tx_done_tick, tx_err_tick}), 32'd0);
    rstn = 1'b1;
    repeat (10) @(negedge clk);

    // Filter behaviour on the clock line while idle.
    idle_glitch(8, 1, "glitch8_one_fall");
    idle_glitch(3, 0, "glitch3_no_fall");

    // 0xED: LED command.
    run_frame(8'hED, 0, 40, 1'b0, bits, dd, de);
    check("ed_bits_literal", 32'(bits), 32'(11'b11111011010));
    check("ed_bits_model",   32'(bits), 32'(frame_model(8'hED)));
    check("ed_inhibit",      32'(inhib_cycles), 32'(INH));
    check("ed_done",         32'(dd), 32'd1);
    check("ed_no_err",       32'(de), 32'd0);

    // 0x01 with a rejected glitch during bit 2.
    run_frame(8'h01, 0, 50, 1'b1, bits, dd, de);
    check("b01_bits_literal", 32'(bits), 32'(11'b10000000010));
    check("b01_done",         32'(dd), 32'd1);
    check("b01_no_err",       32'(de), 32'd0);

    // Missing ACK.
    run_frame(8'hA5, 1, 40, 1'b0, bits, dd, de);
    check("noack_bits_model", 32'(bits), 32'(frame_model(8'hA5)));
    check("noack_err",        32'(de), 32'd1);
    check("noack_no_done",    32'(dd), 32'd0);

    // Device never clocks after the inhibit.
    run_frame(8'h3C, 2, 40, 1'b0, bits, dd, de);
    check("timeout_err",       32'(de), 32'd1);
    check("timeout_no_done",   32'(dd), 32'd0);
    check("timeout_cycles",    32'(dlow_cycles), 32'(TMO));
    check("timeout_start_bit", 32'(bits[0]), 32'd0);
    check("timeout_idle",      32'({tx_busy, ps2c_oe, ps2d_oe}), 32'd0);

    // Reset in the middle of data bit 4, then a fresh 0xFF frame.
    run_frame(8'h96, 3, 40, 1'b0, bits, dd, de);
    check("rst_no_done", 32'(dd), 32'd0);
    check("rst_no_err",  32'(de), 32'd0);
    repeat (20) @(negedge clk);
    run_frame(8'hFF, 0, 40, 1'b0, bits, dd, de);
    check("ff_bits_literal", 32'(bits), 32'(11'b11111111110));
    check("ff_done",         32'(dd), 32'd1);

    // tx_start pulses during a frame are dropped.
    s0 = starts;
    fork
      run_frame(8'h5A, 0, 40, 1'b0, bits, dd, de);
      begin
        repeat (300) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          tx_data  = 8'hC3;
          tx_start = 1'b1;
          @(negedge clk);
          tx_start = 1'b0;
          repeat (500) @(negedge clk);
        end
      end
    join
    check("busy_start_bits",  32'(bits), 32'(frame_model(8'h5A)));
    check("busy_start_done",  32'(dd), 32'd1);
    repeat (200) @(negedge clk);
    check("busy_start_single", 32'(starts - s0), 32'd1);

    // tx_start held through the done edge is dropped there and accepted a cycle later.
    s0 = done_cnt;
    tx_data  = 8'h81;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    device_frame(0, 40, 1'b0, bits);
    check("reaccept_first_bits", 32'(bits), 32'(frame_model(8'h81)));
    tx_data  = 8'h7E;
    tx_start = 1'b1;
    check("reaccept_held_while_busy", 32'(tx_busy), 32'd1);
    n = 0;
    while (!tx_done_tick && n <= 200) begin
      @(negedge clk);
      n++;
    end
    check("reaccept_done_seen", 32'(tx_done_tick), 32'd1);
    check("reaccept_idle_in_done", 32'(tx_busy), 32'd0);
    @(negedge clk);
    tx_start = 1'b0;
    check("reaccept_busy_next", 32'(tx_busy), 32'd1);
    device_frame(0, 40, 1'b0, bits);
    check("reaccept_second_bits", 32'(bits), 32'(frame_model(8'h7E)));
    n = 0;
    while (tx_busy && n <= 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("reaccept_two_done", 32'(done_cnt - s0), 32'd2);

    // Randomised bytes, clock rates and in-frame glitches.
    for (int i = 0; i < 8; i++) begin
      rd = 8'($urandom_range(0, 255));
      rh = $urandom_range(25, 60);
      rg = 1'($urandom_range(0, 1));
      run_frame(rd, 0, rh, rg, bits, dd, de);
      check("rand_bits",    32'(bits), 32'(frame_model(rd)));
      check("rand_inhibit", 32'(inhib_cycles), 32'(INH));
      check("rand_done",    32'(dd), 32'd1);
      check("rand_no_err",  32'(de), 32'd0);
    end

    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
